// File: rtl/multiword_add_sequencer_if.sv
// Bundle of the issue-side handshake and the shared-adder datapath signals
// for multiword_add_sequencer.
//   slave  : the sequencer view (takes requests, drives the adder operands)
//   master : the environment view (issue logic plus the external N-bit adder)
// Signals:
//   start/sub/op_a/op_b            request and operands, sampled on accept
//   busy/done/result/carry_out/overflow  status and wide result
//   adder_a/adder_b/adder_cin      slice operands to the external adder
//   adder_sum/adder_cout           combinational adder response
interface multiword_add_sequencer_if #(
    parameter int N     = 32,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [N-1:0] adder_a;
    logic [N-1:0] adder_b;
    logic         adder_cin;
    logic [N-1:0] adder_sum;
    logic         adder_cout;

    modport slave (
        input  start, sub, op_a, op_b, adder_sum, adder_cout,
        output busy, done, result, carry_out, overflow,
               adder_a, adder_b, adder_cin
    );

    modport master (
        output start, sub, op_a, op_b, adder_sum, adder_cout,
        input  busy, done, result, carry_out, overflow,
               adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Performs a W = N*WORDS bit add or subtract on one external N-bit adder,
// one slice per cycle starting at the least significant slice. The carry is
// chained between slices in a register; the final slice also yields the
// carry-out and signed-overflow flags.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    multiword_add_sequencer_if.slave (request, status, adder slice)
module multiword_add_sequencer #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic clk,
    input  logic rst_n,
    multiword_add_sequencer_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic [IW-1:0] idx_reg;
    logic          carry_reg;
    logic          carry_out_reg;
    logic          overflow_reg;

    logic [N-1:0]  a_slice     [WORDS];
    logic [N-1:0]  b_slice     [WORDS];
    logic [N-1:0]  result_word [WORDS];

    logic          accept;
    logic          running;
    logic          last_slice;

    assign running    = (state_reg == RUN);
    assign last_slice = (idx_reg == IW'(WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; a request is honoured in IDLE and in DONE, never in RUN
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, carry chain and final flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.op_b;
            sub_reg   <= bus.sub;
            idx_reg   <= '0;
            // Subtraction is A + ~B + 1: the +1 enters as the first carry
            carry_reg <= bus.sub;
        end else if (running) begin
            carry_reg <= bus.adder_cout;
            if (last_slice) begin
                carry_out_reg <= bus.adder_cout;
                // Signed overflow: operands agree in sign, sum disagrees
                overflow_reg  <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) &&
                                 (bus.adder_sum[N-1] != a_reg[W-1]);
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Per-slice views of the operands and per-slice result registers
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*N +: N];
            assign b_slice[gi] = b_reg[gi*N +: N];

            always_ff @(posedge clk) begin
                if (!rst_n || accept) begin
                    result_word[gi] <= '0;
                end else if (running && (idx_reg == IW'(gi))) begin
                    result_word[gi] <= bus.adder_sum;
                end
            end

            assign bus.result[gi*N +: N] = result_word[gi];
        end
    endgenerate

    // Adder operands come only from registered state, so start never
    // reaches the shared adder combinationally; idle states drive zeros.
    assign bus.adder_a   = running ? a_slice[idx_reg] : '0;
    assign bus.adder_b   = running ? (b_slice[idx_reg] ^ {N{sub_reg}}) : '0;
    assign bus.adder_cin = running & carry_reg;

    assign bus.busy      = running;
    assign bus.done      = (state_reg == DONE);
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multiword_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

    multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural N-bit adder on the shared-adder ports
    assign {bus.adder_cout, bus.adder_sum} =
        {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {{N{1'b0}}, bus.adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wide reference: returns {overflow, carry, result}
    function automatic logic [W+1:0] ref_op(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         v;
        beff = b ^ {W{s}};
        full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, s};
        v    = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
        return {v, full};
    endfunction

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one op from IDLE, wait (bounded) for done.
    // cyc: post-edge sample index at which done was seen (accept edge = 0)
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc, output int busy_cnt,
                          output logic cin1, output logic [N-1:0] b1,
                          output logic [N-1:0] b2);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc       = 1;
        busy_cnt  = 0;
        cin1      = 1'b0;
        b1        = '0;
        b2        = '0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) busy_cnt++;
            if (cyc == 1) begin
                cin1 = bus.adder_cin;
                b1   = bus.adder_b;
            end
            if (cyc == 2) b2 = bus.adder_b;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_c, input logic exp_v);
        int           cyc;
        int           busy_cnt;
        logic         cin1;
        logic [N-1:0] b1;
        logic [N-1:0] b2;
        run_op(s, a, b, cyc, busy_cnt, cin1, b1, b2);
        check({tag, "_latency"}, W'(cyc), W'(5));
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_carry"}, W'(bus.carry_out), W'(exp_c));
        check({tag, "_ovf"}, W'(bus.overflow), W'(exp_v));
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, W'(bus.done), W'(0));
        $display("op %s sub=%0d result=%h c=%0d v=%0d", tag, s, bus.result,
                 bus.carry_out, bus.overflow);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] a_hist [20];
    logic [W-1:0] b_hist [20];
    logic         s_hist [20];

    initial begin
        int           cyc;
        int           busy_cnt;
        logic         cin1;
        logic [N-1:0] b1;
        logic [N-1:0] b2;
        logic [W+1:0] r;

        checks    = 0;
        errors    = 0;
        ones      = '1;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_result", bus.result, '0);
        check("rst_carry", W'(bus.carry_out), W'(0));
        check("rst_ovf", W'(bus.overflow), W'(0));
        check("rst_adder_a", W'(bus.adder_a), W'(0));
        check("rst_adder_b", W'(bus.adder_b), W'(0));
        check("rst_adder_cin", W'(bus.adder_cin), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: all-ones + 1 wraps to zero with carry out
        run_op(1'b0, ones, W'(1), cyc, busy_cnt, cin1, b1, b2);
        check("t1_latency", W'(cyc), W'(5));
        check("t1_busy_cycles", W'(busy_cnt), W'(4));
        check("t1_result", bus.result, '0);
        check("t1_carry", W'(bus.carry_out), W'(1));
        check("t1_ovf", W'(bus.overflow), W'(0));
        $display("op t1 result=%h c=%0d v=%0d", bus.result, bus.carry_out, bus.overflow);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", W'(bus.done), W'(0));

        // 2: 0 - 1 borrows; slice 0 sees ~1 with cin=1, slice 1 sees ~0
        run_op(1'b1, '0, W'(1), cyc, busy_cnt, cin1, b1, b2);
        check("t2_first_cin", W'(cin1), W'(1));
        check("t2_first_adder_b", W'(b1), W'(32'hFFFF_FFFE));
        check("t2_second_adder_b", W'(b2), W'(32'hFFFF_FFFF));
        check("t2_latency", W'(cyc), W'(5));
        check("t2_result", bus.result, ones);
        check("t2_carry", W'(bus.carry_out), W'(0));
        check("t2_ovf", W'(bus.overflow), W'(0));
        $display("op t2 result=%h c=%0d v=%0d", bus.result, bus.carry_out, bus.overflow);
        @(posedge clk);
        #1;

        // 3: max positive + 1 overflows into the sign bit
        do_op("t3", 1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);

        // Extra directed: signed min - 1 overflows, no borrow
        do_op("t3b", 1'b1, {1'b1, {(W-1){1'b0}}}, W'(1), {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1);

        // 4: start held high, operands change every cycle; accepts at
        // edges 0,5,10,15, done seen after edges 4,9,14,19
        for (int c = 0; c < 20; c++) begin
            a_hist[c] = rand_w();
            b_hist[c] = rand_w();
            s_hist[c] = c[0];
            bus.start = 1'b1;
            bus.op_a  = a_hist[c];
            bus.op_b  = b_hist[c];
            bus.sub   = s_hist[c];
            @(posedge clk);
            #1;
            check("t4_done_timing", W'(bus.done), W'((c % 5) == 4));
            if ((c % 5) == 4) begin
                r = ref_op(s_hist[c-4], a_hist[c-4], b_hist[c-4]);
                check("t4_result", bus.result, r[W-1:0]);
                check("t4_carry", W'(bus.carry_out), W'(r[W]));
                check("t4_ovf", W'(bus.overflow), W'(r[W+1]));
                $display("op t4 cycle=%0d result=%h c=%0d v=%0d", c, bus.result,
                         bus.carry_out, bus.overflow);
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("t4_back_to_idle", W'(bus.busy | bus.done), W'(0));

        // 5: reset while idx==2 aborts with no done pulse
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op_a  = ones;
        bus.op_b  = ones;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_busy_before_rst", W'(bus.busy), W'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_busy", W'(bus.busy), W'(0));
        check("t5_result", bus.result, '0);
        check("t5_carry", W'(bus.carry_out), W'(0));
        check("t5_ovf", W'(bus.overflow), W'(0));
        check("t5_done", W'(bus.done), W'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t5_no_done", W'(bus.done), W'(0));
        end
        $display("op t5 reset abort result=%h", bus.result);
        do_op("t5_after", 1'b0, W'(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321),
              W'(128'h1111_1111_1111_1111_1111_1111_1111_1111),
              W'(128'h2345_6789_ABCD_F001_20FE_DCBA_9876_5432), 1'b0, 1'b0);

        // 6: random add/sub against the wide reference
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = rand_w();
            rb = rand_w();
            rs = $urandom_range(0, 1) == 1;
            if (i % 10 == 0) rb = ra;
            r = ref_op(rs, ra, rb);
            do_op("t6", rs, ra, rb, r[W-1:0], r[W], r[W+1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
